// File: rtl/lcd_64_to_32_bits_dfa_ram_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_64_to_32_bits_dfa_ram_ctrl
// FIFO sequencer for the data-format-adapter lookahead data RAM. Owns the RAM
// write port and read port 0, tracks write/read pointers, and hides the RAM's
// one-cycle read latency behind a 2-entry output buffer so the RAM looks like
// a ready/valid streaming FIFO.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   flush                        synchronous clear of stored and in-flight data
//   sink_valid/ready/data        input stream
//   source_valid/ready/data      output stream
//   wr_address/writedata/write   RAM write port
//   wr_waitrequest               RAM busy; no RAM access while high
//   rd0_address, rd0_readdata    RAM read port 0 (data returns next cycle)
//   fill_level                   words held (RAM + in-flight read + buffer)
// -----------------------------------------------------------------------------
module lcd_64_to_32_bits_dfa_ram_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     sink_valid,
    output logic                     sink_ready,
    input  logic [DATA_WIDTH-1:0]    sink_data,
    output logic                     source_valid,
    input  logic                     source_ready,
    output logic [DATA_WIDTH-1:0]    source_data,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0]    wr_writedata,
    output logic                     wr_write,
    input  logic                     wr_waitrequest,
    output logic [ADDRESS_WIDTH-1:0] rd0_address,
    input  logic [DATA_WIDTH-1:0]    rd0_readdata,
    output logic [ADDRESS_WIDTH+1:0] fill_level
);

    localparam int unsigned PTR_W  = ADDRESS_WIDTH + 1;
    localparam int unsigned FILL_W = ADDRESS_WIDTH + 2;
    localparam int unsigned DEPTH  = 2 ** ADDRESS_WIDTH;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      used, used_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] ob_q [2];
    logic [DATA_WIDTH-1:0] ob_d [2];
    logic                  ob_head_q, ob_head_d;
    logic                  ob_tail_q, ob_tail_d;
    logic [1:0]            ob_count_q, ob_count_d;
    logic [FILL_W-1:0]     fill_level_q, fill_level_d;

    logic full, empty, push, pop, ob_room, rd_issue;

    // Occupancy of the RAM part; the extra pointer bit separates full from empty.
    assign used  = wr_ptr_q - rd_ptr_q;
    assign full  = (used == PTR_W'(DEPTH));
    assign empty = (used == '0);

    // Stream handshakes and RAM port drive.
    assign sink_ready   = !full && !wr_waitrequest && !flush;
    assign push         = sink_valid && sink_ready;
    assign wr_write     = push;
    assign wr_address   = wr_ptr_q[ADDRESS_WIDTH-1:0];
    assign wr_writedata = sink_data;

    assign source_valid = (ob_count_q != 2'd0);
    assign source_data  = ob_q[ob_head_q];
    assign pop          = source_valid && source_ready;

    // A read is issued only if the buffer has a slot reserved for its return.
    assign ob_room  = (3'(ob_count_q) + 3'(pend_q) - 3'(pop)) < 3'd2;
    assign rd_issue = !empty && !wr_waitrequest && !flush && ob_room;

    assign rd0_address = rd_ptr_q[ADDRESS_WIDTH-1:0];
    assign fill_level  = fill_level_q;

    // Next-state for pointers, in-flight flag and output buffer.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pend_d     = 1'b0;
        ob_d       = ob_q;
        ob_head_d  = ob_head_q;
        ob_tail_d  = ob_tail_q;
        ob_count_d = ob_count_q;

        if (flush) begin
            // Read data returning next cycle is dropped because pend clears.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ob_head_d  = 1'b0;
            ob_tail_d  = 1'b0;
            ob_count_d = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            pend_d = rd_issue;
            if (pend_q) begin
                ob_d[ob_tail_q] = rd0_readdata;
                ob_tail_d       = ~ob_tail_q;
            end
            if (pop) begin
                ob_head_d = ~ob_head_q;
            end
            ob_count_d = ob_count_q + 2'(pend_q) - 2'(pop);
        end

        used_d       = wr_ptr_d - rd_ptr_d;
        fill_level_d = FILL_W'(used_d) + FILL_W'(pend_d) + FILL_W'(ob_count_d);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_q       <= 1'b0;
            ob_q         <= '{default: '0};
            ob_head_q    <= 1'b0;
            ob_tail_q    <= 1'b0;
            ob_count_q   <= 2'd0;
            fill_level_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_q       <= pend_d;
            ob_q         <= ob_d;
            ob_head_q    <= ob_head_d;
            ob_tail_q    <= ob_tail_d;
            ob_count_q   <= ob_count_d;
            fill_level_q <= fill_level_d;
        end
    end

endmodule

// File: tb/tb_lcd_64_to_32_bits_dfa_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_64_to_32_bits_dfa_ram_ctrl
// Bench for the lookahead RAM FIFO sequencer with a behavioural 1-cycle-latency
// RAM and a queue scoreboard of accepted vs emitted words.
// -----------------------------------------------------------------------------
module tb_lcd_64_to_32_bits_dfa_ram_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          sink_valid;
    logic          sink_ready;
    logic [DW-1:0] sink_data;
    logic          source_valid;
    logic          source_ready;
    logic [DW-1:0] source_data;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_writedata;
    logic          wr_write;
    logic          wr_waitrequest;
    logic [AW-1:0] rd0_address;
    logic [DW-1:0] rd0_readdata;
    logic [AW+1:0] fill_level;

    always #5 clk = ~clk;

    lcd_64_to_32_bits_dfa_ram_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .sink_valid     (sink_valid),
        .sink_ready     (sink_ready),
        .sink_data      (sink_data),
        .source_valid   (source_valid),
        .source_ready   (source_ready),
        .source_data    (source_data),
        .wr_address     (wr_address),
        .wr_writedata   (wr_writedata),
        .wr_write       (wr_write),
        .wr_waitrequest (wr_waitrequest),
        .rd0_address    (rd0_address),
        .rd0_readdata   (rd0_readdata),
        .fill_level     (fill_level)
    );

    // RAM model: synchronous write, read data registered one cycle after address.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (wr_write) mem[wr_address] <= wr_writedata;
        rd0_readdata <= mem[rd0_address];
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int sb_count   = 0;
    int push_count = 0;
    int pop_count  = 0;

    // Scoreboard recording: accepted words are expected, emitted words are got.
    always @(negedge clk) begin
        if (reset_n) begin
            if (flush) begin
                for (int i = 0; i < sb_count; i++) void'(exp_q.pop_back());
                sb_count <= 0;
            end else begin
                if (sink_valid && sink_ready) begin
                    exp_q.push_back(sink_data);
                    push_count <= push_count + 1;
                end
                if (source_valid && source_ready) begin
                    got_q.push_back(source_data);
                    pop_count <= pop_count + 1;
                end
                sb_count <= sb_count + int'(sink_valid && sink_ready)
                                     - int'(source_valid && source_ready);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; sink_valid = 1'b0; sink_data = '0;
        source_ready = 1'b0; wr_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (source_valid !== 1'b0 || fill_level !== '0 || source_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b fill=%0d data=%0h expected 0/0/0",
                     source_valid, fill_level, source_data);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; sink_valid = 1'b1; sink_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (sink_ready !== 1'b0 || wr_write !== 1'b0 || source_valid !== 1'b0 || fill_level !== '0) begin
                n_fail++;
                $display("FAIL waitrequest_hold[%0d]: ready=%0b write=%0b valid=%0b fill=%0d expected 0/0/0/0",
                         i, sink_ready, wr_write, source_valid, fill_level);
            end
            @(posedge clk); #1;
        end
        wr_waitrequest = 1'b0; sink_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sink_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_wait: got %0b expected 1", sink_ready);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        sink_valid = 1'b1; sink_data = 8'hA5; source_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            case (c)
                0: if (wr_write !== 1'b1 || wr_address !== 2'd0 || wr_writedata !== 8'hA5 || source_valid !== 1'b0) begin
                       n_fail++;
                       $display("FAIL single_write: write=%0b addr=%0d data=%0h valid=%0b expected 1/0/a5/0",
                                wr_write, wr_address, wr_writedata, source_valid);
                   end
                1: if (wr_write !== 1'b0 || rd0_address !== 2'd0 || source_valid !== 1'b0 || fill_level !== 4'd1) begin
                       n_fail++;
                       $display("FAIL single_issue: write=%0b raddr=%0d valid=%0b fill=%0d expected 0/0/0/1",
                                wr_write, rd0_address, source_valid, fill_level);
                   end
                2: if (rd0_address !== 2'd1 || source_valid !== 1'b0 || fill_level !== 4'd1) begin
                       n_fail++;
                       $display("FAIL single_inflight: raddr=%0d valid=%0b fill=%0d expected 1/0/1",
                                rd0_address, source_valid, fill_level);
                   end
                3: if (source_valid !== 1'b1 || source_data !== 8'hA5) begin
                       n_fail++;
                       $display("FAIL single_out: valid=%0b data=%0h expected 1/a5", source_valid, source_data);
                   end
                default: if (source_valid !== 1'b0 || fill_level !== '0) begin
                       n_fail++;
                       $display("FAIL single_after[%0d]: valid=%0b fill=%0d expected 0/0", c, source_valid, fill_level);
                   end
            endcase
            @(posedge clk); #1;
            sink_valid = 1'b0;
        end
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_sb: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int first_v = -1, last_v = -1, nv = 0, base = push_count;
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            sink_valid = (i < 16); sink_data = DW'(i); source_ready = 1'b1;
            @(negedge clk);
            if (i < 16) begin
                n_checks++;
                if (sink_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got %0b expected 1", i, sink_ready);
                end
            end
            if (source_valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            @(posedge clk); #1;
        end
        sink_valid = 1'b0;
        n_checks++;
        if (nv != 16 || first_v != 3 || last_v != 18 || push_count - base != 16) begin
            n_fail++;
            $display("FAIL b2b_timing: outs=%0d first=%0d last=%0d pushes=%0d expected 16/3/18/16",
                     nv, first_v, last_v, push_count - base);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL b2b_data: got %0h expected %0h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int acc = 0, first_pop = -1, ready_at = -1;
        bit adv;
        source_ready = 1'b0; sink_valid = 1'b1; sink_data = 8'h40;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            adv = sink_ready;
            if (adv) acc++;
            @(posedge clk); #1;
            if (adv) sink_data = sink_data + 8'd1;
        end
        sink_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (acc != 6 || sink_ready !== 1'b0 || fill_level !== 4'd6) begin
            n_fail++;
            $display("FAIL bp_fill: accepted=%0d ready=%0b fill=%0d expected 6/0/6", acc, sink_ready, fill_level);
        end
        @(posedge clk); #1;
        source_ready = 1'b1;
        for (int i = 0; i < 30 && got_q.size() < 6; i++) begin
            @(negedge clk);
            if (source_valid && first_pop < 0) first_pop = i;
            if (first_pop >= 0 && sink_ready && ready_at < 0) ready_at = i;
            @(posedge clk); #1;
        end
        n_checks++;
        if (first_pop < 0 || ready_at < 0 || ready_at - first_pop > 2) begin
            n_fail++;
            $display("FAIL bp_ready_return: first_pop=%0d ready_at=%0d expected gap <= 2", first_pop, ready_at);
        end
        n_checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected 6 (sb %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp_data: got %0h expected %0h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int base = push_count;
        bit done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (int'(fill_level) != sb_count || fill_level > 4'd6) begin
                n_fail++;
                $display("FAIL rand_fill: got %0d expected %0d", fill_level, sb_count);
            end
            if (push_count - base >= 200 && sb_count == 0) done = 1'b1;
            sink_valid   = (push_count - base < 200) && ($urandom_range(0, 1) == 1);
            sink_data    = DW'($urandom);
            source_ready = ($urandom_range(0, 1) == 1);
        end
        sink_valid = 1'b0;
        n_checks++;
        if (!done || got_q.size() != 200 || exp_q.size() != 200) begin
            n_fail++;
            $display("FAIL rand_complete: got %0d words expected 200 (sb %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rand_data: got %0h expected %0h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        int n_out = 0;
        logic [DW-1:0] last_out = '0;
        @(posedge clk); #1;
        source_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sink_valid = 1'b1; sink_data = 8'h50 + DW'(i);
            source_ready = (i == 5);
            @(posedge clk); #1;
        end
        sink_valid = 1'b0; source_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fill_level !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_pre_fill: got %0d expected 5", fill_level);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (source_valid !== 1'b0 || fill_level !== '0) begin
                n_fail++;
                $display("FAIL flush_clear[%0d]: valid=%0b fill=%0d expected 0/0", i, source_valid, fill_level);
            end
            @(posedge clk); #1;
        end
        sink_valid = 1'b1; sink_data = 8'h3C; source_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (source_valid) begin
                n_out++;
                last_out = source_data;
            end
            @(posedge clk); #1;
            sink_valid = 1'b0;
        end
        n_checks++;
        if (n_out != 1 || last_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL flush_after: outs=%0d data=%0h expected 1/3c", n_out, last_out);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL flush_sb_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL flush_data: got %0h expected %0h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
